// File: rtl/plm_pkg.sv
// Shared field layout, width helpers and read-tag type for the PLM bank arbiter.
package plm_pkg;

    localparam int VALID_BIT     = 0;
    localparam int WR_BIT        = 1;
    localparam int VALUE_LSB     = 2;
    localparam int MAX_CONSUMERS = 8;
    localparam int TAG_ID_WIDTH  = $clog2(MAX_CONSUMERS);

    typedef struct packed {
        logic                    is_read;
        logic [TAG_ID_WIDTH-1:0] id;
    } tag_t;

    function automatic int bank_bits(input int nbanks);
        return $clog2(nbanks);
    endfunction

    function automatic int req_width(input int addr_width, input int value_width);
        return addr_width + value_width + 2;
    endfunction

    function automatic int plm_input_width(input int addr_width, input int value_width,
                                           input int nbanks);
        return addr_width - bank_bits(nbanks) + value_width + 1;
    endfunction

endpackage

// File: rtl/plm_bank_arbiter_if.sv
// Consumer request/response and PLM port bundle shared by the arbiter and its environment.
interface plm_bank_arbiter_if
    import plm_pkg::*;
#(
    parameter int NCONSUMERS  = 8,
    parameter int NBANKS      = 4,
    parameter int NPORTS      = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int VALUE_WIDTH = 8
);
    localparam int REQ_W = req_width(ADDR_WIDTH, VALUE_WIDTH);
    localparam int PLM_W = plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS);

    logic [REQ_W-1:0]       requests   [NCONSUMERS];
    logic [NCONSUMERS-1:0]  grants;
    logic [PLM_W-1:0]       plm_inputs [NPORTS];
    logic [NPORTS-1:0]      plm_en;
    logic [VALUE_WIDTH-1:0] plm_rdata  [NPORTS];
    logic [NCONSUMERS-1:0]  resp_valid;
    logic [VALUE_WIDTH-1:0] resp_data  [NCONSUMERS];

    modport master (
        output requests, plm_rdata,
        input  grants, plm_inputs, plm_en, resp_valid, resp_data
    );

    modport slave (
        input  requests, plm_rdata,
        output grants, plm_inputs, plm_en, resp_valid, resp_data
    );

endinterface

// File: rtl/read_tag_pipeline.sv
// One PLM port's read tag delay line; the final stage lines up with that port's read data.
module read_tag_pipeline
    import plm_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t load_tag,
    output tag_t final_tag
);

    tag_t stage_r [DEPTH];

    // Shift the tag one stage per cycle; reset drops every in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= load_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign final_tag = stage_r[DEPTH-1];

endmodule

// File: rtl/plm_bank_arbiter.sv
// Per-bank round-robin arbiter: grants up to NPORTS consumers per cycle onto one PLM bank
// and routes returning read data back to the consumer that issued it.
module plm_bank_arbiter
    import plm_pkg::*;
#(
    parameter int NCONSUMERS   = 8,
    parameter int NBANKS       = 4,
    parameter int NPORTS       = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int VALUE_WIDTH  = 8,
    parameter int BANK_ID      = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    plm_bank_arbiter_if.slave bus
);

    localparam int BANK_BITS = bank_bits(NBANKS);
    localparam int REQ_W     = req_width(ADDR_WIDTH, VALUE_WIDTH);
    localparam int PLM_W     = plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS);
    localparam int ADDR_LSB  = VALUE_LSB + VALUE_WIDTH;
    localparam int PTR_W     = $clog2(NCONSUMERS);

    logic [NCONSUMERS-1:0]  eligible_s;
    logic [NCONSUMERS-1:0]  grant_s;
    logic [NPORTS-1:0]      port_vld_s;
    logic [PTR_W-1:0]       port_id_s    [NPORTS];
    logic [PTR_W-1:0]       ptr_r;
    logic [PTR_W-1:0]       ptr_next_s;
    logic [PLM_W-1:0]       plm_word_s   [NPORTS];
    logic [PLM_W-1:0]       plm_inputs_r [NPORTS];
    logic [NPORTS-1:0]      plm_en_r;
    logic [PTR_W-1:0]       port_id_r    [NPORTS];
    tag_t                   load_tag_s   [NPORTS];
    tag_t                   final_tag_s  [NPORTS];
    logic [NCONSUMERS-1:0]  resp_valid_r;
    logic [VALUE_WIDTH-1:0] resp_data_r  [NCONSUMERS];

    // Eligibility: a valid request whose low-order interleave bits select this bank
    always_comb begin
        eligible_s = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            if (bus.requests[c][VALID_BIT] &&
                (bus.requests[c][ADDR_LSB +: BANK_BITS] == BANK_BITS'(BANK_ID))) begin
                eligible_s[c] = 1'b1;
            end else begin
                eligible_s[c] = 1'b0;
            end
        end
    end

    // Circular scan from ptr; the k-th winner takes port k and ptr moves past the last winner
    always_comb begin
        int n_granted;
        int idx;
        grant_s    = '0;
        port_vld_s = '0;
        ptr_next_s = ptr_r;
        n_granted  = 0;
        idx        = 0;
        for (int k = 0; k < NPORTS; k++) begin
            port_id_s[k] = '0;
        end
        if (reset) begin
            grant_s = '0;
        end else begin
            for (int i = 0; i < NCONSUMERS; i++) begin
                idx = (int'(ptr_r) + i) % NCONSUMERS;
                if (eligible_s[idx] && (n_granted < NPORTS)) begin
                    grant_s[idx]          = 1'b1;
                    port_vld_s[n_granted] = 1'b1;
                    port_id_s[n_granted]  = PTR_W'(idx);
                    ptr_next_s            = PTR_W'((idx + 1) % NCONSUMERS);
                    n_granted             = n_granted + 1;
                end else begin
                    n_granted = n_granted;
                end
            end
        end
    end

    // PLM port word: bank-local address (interleave bits stripped), value, write flag
    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            plm_word_s[k] = '0;
            if (port_vld_s[k]) begin
                plm_word_s[k] = {bus.requests[port_id_s[k]][REQ_W-1 -: ADDR_WIDTH-BANK_BITS],
                                 bus.requests[port_id_s[k]][VALUE_LSB +: VALUE_WIDTH],
                                 bus.requests[port_id_s[k]][WR_BIT]};
            end else begin
                plm_word_s[k] = '0;
            end
        end
    end

    // Port registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r    <= '0;
            plm_en_r <= '0;
            for (int k = 0; k < NPORTS; k++) begin
                plm_inputs_r[k] <= '0;
                port_id_r[k]    <= '0;
            end
        end else begin
            ptr_r    <= ptr_next_s;
            plm_en_r <= port_vld_s;
            for (int k = 0; k < NPORTS; k++) begin
                plm_inputs_r[k] <= plm_word_s[k];
                port_id_r[k]    <= port_id_s[k];
            end
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        assign load_tag_s[k] = {plm_en_r[k] & ~plm_inputs_r[k][0],
                                TAG_ID_WIDTH'(port_id_r[k])};

        read_tag_pipeline #(
            .DEPTH (READ_LATENCY)
        ) u_tags (
            .clk       (clk),
            .reset     (reset),
            .load_tag  (load_tag_s[k]),
            .final_tag (final_tag_s[k])
        );
    end

    // Read return; ports scanned high to low so port 0 wins a same-consumer collision
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= '0;
            for (int c = 0; c < NCONSUMERS; c++) begin
                resp_data_r[c] <= '0;
            end
        end else begin
            resp_valid_r <= '0;
            for (int p = NPORTS - 1; p >= 0; p--) begin
                if (final_tag_s[p].is_read) begin
                    resp_valid_r[final_tag_s[p].id] <= 1'b1;
                    resp_data_r[final_tag_s[p].id]  <= bus.plm_rdata[p];
                end
            end
        end
    end

    assign bus.grants     = grant_s;
    assign bus.plm_inputs = plm_inputs_r;
    assign bus.plm_en     = plm_en_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;

endmodule

// File: tb/tb_plm_bank_arbiter.sv
// Bench for plm_bank_arbiter: directed sequences, a vector table and a randomized run
// against a memory-level reference model with a simple PLM stand-in.
module tb_plm_bank_arbiter;

    localparam int NC    = 8;
    localparam int NP    = 2;
    localparam int NCYC  = 400;
    localparam int NVEC  = 10;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] g;
        int         p0;
        int         p1;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    plm_bank_arbiter_if #(.NCONSUMERS(NC), .NBANKS(4), .NPORTS(NP),
                          .ADDR_WIDTH(16), .VALUE_WIDTH(8)) bus ();

    plm_bank_arbiter #(
        .NCONSUMERS(NC), .NBANKS(4), .NPORTS(NP), .ADDR_WIDTH(16),
        .VALUE_WIDTH(8), .BANK_ID(0), .READ_LATENCY(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] mkreq(input logic [15:0] a, input logic [7:0] v,
                                          input logic wr, input logic vld);
        return {a, v, wr, vld};
    endfunction

    function automatic logic [22:0] mkplm(input logic [15:0] a, input logic [7:0] v,
                                          input logic wr);
        return {a[15:2], v, wr};
    endfunction

    function automatic logic [22:0] tword(input int id);
        if (id < 0) return 23'h0;
        return mkplm(16'h0100 + 16'(id * 4), 8'h10 + 8'(id), 1'b1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int c = 0; c < NC; c++) bus.requests[c] = '0;
    endtask

    // reference model state for the randomized run
    vec_t        tbl [NVEC];
    logic [7:0]  refmem [16384];
    logic [7:0]  plmmem [16384];
    logic        have_req [NC];
    logic [15:0] r_addr [NC];
    logic [7:0]  r_val [NC];
    logic        r_wr [NC];
    logic [1:0]  e_en [NCYC+4];
    logic [22:0] e_in [NCYC+4][NP];
    logic [7:0]  e_rv [NCYC+4];
    logic [7:0]  e_rd [NCYC+4][NC];
    logic        pr_vld [NP];
    logic [13:0] pr_addr [NP];
    logic        pw_vld [NP];
    logic [13:0] pw_addr [NP];
    logic [7:0]  pw_val [NP];
    int          mptr;
    int          elig_q [$];
    logic [7:0]  g_exp;
    logic [22:0] w23;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{8'h2A, 8'h00, 8'h0A,  1,  3};
        tbl[1] = '{8'h2A, 8'h00, 8'h22,  5,  1};
        tbl[2] = '{8'h2A, 8'h00, 8'h28,  3,  5};
        tbl[3] = '{8'h00, 8'h04, 8'h00, -1, -1};
        tbl[4] = '{8'h81, 8'h00, 8'h81,  7,  0};
        tbl[5] = '{8'h01, 8'h00, 8'h01,  0, -1};
        tbl[6] = '{8'hFF, 8'h00, 8'h06,  1,  2};
        tbl[7] = '{8'h00, 8'h00, 8'h00, -1, -1};
        tbl[8] = '{8'hFF, 8'h00, 8'h18,  3,  4};
        tbl[9] = '{8'h40, 8'h20, 8'h40,  6, -1};

        // reset holds everything quiet even with a pending eligible request
        reset = 1'b1;
        clear_reqs();
        for (int p = 0; p < NP; p++) bus.plm_rdata[p] = '0;
        bus.requests[3] = mkreq(16'h0004, 8'h55, 1'b1, 1'b1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #3;
            check("rst_grants", 64'(bus.grants), 64'h0);
            check("rst_plm_en", 64'(bus.plm_en), 64'h0);
            check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
            cyc();
        end
        reset = 1'b0;
        #3;
        check("first_grant", 64'(bus.grants), 64'h08);
        cyc();
        clear_reqs();
        check("first_plm_en", 64'(bus.plm_en), 64'h1);
        check("first_plm_in", 64'(bus.plm_inputs[0]), 64'(mkplm(16'h0004, 8'h55, 1'b1)));

        // single write from consumer 0
        bus.requests[0] = mkreq(16'h0008, 8'h19, 1'b1, 1'b1);
        #3;
        check("wr_grant", 64'(bus.grants), 64'h01);
        cyc();
        clear_reqs();
        w23 = {14'h0002, 8'h19, 1'b1};
        check("wr_plm_in", 64'(bus.plm_inputs[0]), 64'(w23));
        check("wr_plm_en", 64'(bus.plm_en), 64'h1);
        check("wr_no_resp", 64'(bus.resp_valid), 64'h0);

        // other-bank request is ignored
        bus.requests[2] = mkreq(16'h0009, 8'h77, 1'b1, 1'b1);
        #3;
        check("bank1_grant", 64'(bus.grants), 64'h0);
        cyc();
        clear_reqs();
        check("bank1_plm_en", 64'(bus.plm_en), 64'h0);
        check("bank1_plm_in", 64'(bus.plm_inputs[0]), 64'h0);

        // read round trip for consumer 6
        bus.requests[6] = mkreq(16'h0010, 8'h00, 1'b0, 1'b1);
        #3;
        check("rd_grant", 64'(bus.grants), 64'h40);
        cyc();
        clear_reqs();
        check("rd_plm_en", 64'(bus.plm_en), 64'h1);
        check("rd_plm_in", 64'(bus.plm_inputs[0]), 64'(mkplm(16'h0010, 8'h00, 1'b0)));
        cyc();
        bus.plm_rdata[0] = 8'hA5;
        #3;
        check("rd_resp_early", 64'(bus.resp_valid), 64'h0);
        cyc();
        bus.plm_rdata[0] = 8'h00;
        check("rd_resp_valid", 64'(bus.resp_valid), 64'h40);
        check("rd_resp_data", 64'(bus.resp_data[6]), 64'hA5);
        cyc();
        check("rd_resp_pulse", 64'(bus.resp_valid), 64'h0);

        // reset while read data is on the bus drops the response
        bus.requests[6] = mkreq(16'h0010, 8'h00, 1'b0, 1'b1);
        #3;
        check("rstrd_grant", 64'(bus.grants), 64'h40);
        cyc();
        clear_reqs();
        cyc();
        bus.plm_rdata[0] = 8'hA5;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.plm_rdata[0] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("rstrd_no_resp", 64'(bus.resp_valid), 64'h0);
            cyc();
        end

        // vector table; pointer starts at 0 after the reset above
        for (int i = 0; i < NVEC; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (tbl[i].b0[c])
                    bus.requests[c] = mkreq(16'h0100 + 16'(c * 4), 8'h10 + 8'(c), 1'b1, 1'b1);
                else if (tbl[i].b1[c])
                    bus.requests[c] = mkreq(16'h0101 + 16'(c * 4), 8'h10 + 8'(c), 1'b1, 1'b1);
                else
                    bus.requests[c] = '0;
            end
            #3;
            check($sformatf("vec%0d_grants", i), 64'(bus.grants), 64'(tbl[i].g));
            cyc();
            check($sformatf("vec%0d_plm_en", i), 64'(bus.plm_en),
                  64'({tbl[i].p1 >= 0, tbl[i].p0 >= 0}));
            check($sformatf("vec%0d_port0", i), 64'(bus.plm_inputs[0]), 64'(tword(tbl[i].p0)));
            check($sformatf("vec%0d_port1", i), 64'(bus.plm_inputs[1]), 64'(tword(tbl[i].p1)));
        end

        // randomized run against the reference model
        clear_reqs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        for (int a = 0; a < 16384; a++) begin
            refmem[a] = 8'h00;
            plmmem[a] = 8'h00;
        end
        for (int t = 0; t < NCYC + 4; t++) begin
            e_en[t] = '0;
            e_rv[t] = '0;
            for (int p = 0; p < NP; p++) e_in[t][p] = '0;
            for (int c = 0; c < NC; c++) e_rd[t][c] = '0;
        end
        for (int c = 0; c < NC; c++) have_req[c] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pr_vld[p] = 1'b0;
            pw_vld[p] = 1'b0;
        end
        mptr = 0;

        for (int t = 0; t < NCYC; t++) begin
            // PLM stand-in: reads see memory before this edge's writes
            for (int p = 0; p < NP; p++)
                bus.plm_rdata[p] = pr_vld[p] ? plmmem[pr_addr[p]] : 8'($urandom);
            for (int p = 0; p < NP; p++)
                if (pw_vld[p]) plmmem[pw_addr[p]] = pw_val[p];

            for (int c = 0; c < NC; c++) begin
                if (!have_req[c] && ($urandom_range(0, 1) == 1)) begin
                    have_req[c] = 1'b1;
                    r_addr[c]   = 16'($urandom_range(0, 63));
                    if ($urandom_range(0, 1) == 1) r_addr[c][1:0] = 2'b00;
                    r_val[c]    = 8'($urandom);
                    r_wr[c]     = 1'($urandom);
                end
                bus.requests[c] = have_req[c] ? mkreq(r_addr[c], r_val[c], r_wr[c], 1'b1) : '0;
            end

            elig_q.delete();
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (mptr + i) % NC;
                if (have_req[c] && (r_addr[c][1:0] == 2'b00) && (elig_q.size() < NP))
                    elig_q.push_back(c);
            end
            g_exp = '0;
            foreach (elig_q[k]) begin
                int c;
                c = elig_q[k];
                g_exp[c]        = 1'b1;
                e_en[t+1][k]    = 1'b1;
                e_in[t+1][k]    = mkplm(r_addr[c], r_val[c], r_wr[c]);
                if (!r_wr[c]) begin
                    e_rv[t+3][c] = 1'b1;
                    e_rd[t+3][c] = refmem[r_addr[c][15:2]];
                end
            end
            foreach (elig_q[k])
                if (r_wr[elig_q[k]]) refmem[r_addr[elig_q[k]][15:2]] = r_val[elig_q[k]];
            if (elig_q.size() > 0) mptr = (elig_q[elig_q.size()-1] + 1) % NC;

            #3;
            check("rnd_grants", 64'(bus.grants), 64'(g_exp));
            check("rnd_plm_en", 64'(bus.plm_en), 64'(e_en[t]));
            for (int p = 0; p < NP; p++)
                check("rnd_plm_in", 64'(bus.plm_inputs[p]), 64'(e_in[t][p]));
            check("rnd_resp_valid", 64'(bus.resp_valid), 64'(e_rv[t]));
            for (int c = 0; c < NC; c++)
                if (e_rv[t][c]) check("rnd_resp_data", 64'(bus.resp_data[c]), 64'(e_rd[t][c]));

            for (int p = 0; p < NP; p++) begin
                pr_vld[p]  = bus.plm_en[p] && !bus.plm_inputs[p][0];
                pw_vld[p]  = bus.plm_en[p] && bus.plm_inputs[p][0];
                pr_addr[p] = bus.plm_inputs[p][22:9];
                pw_addr[p] = bus.plm_inputs[p][22:9];
                pw_val[p]  = bus.plm_inputs[p][8:1];
            end
            foreach (elig_q[k]) have_req[elig_q[k]] = 1'b0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
